// File: rtl/ray_march_ctrl.sv
// ray_march_ctrl: sphere-tracing controller for a single ray.
//   Each iteration sends one position to an external SDF evaluator, consumes
//   the returned distance and advances along the ray. The loop ends on a hit
//   (distance < EPS), after MAX_STEPS responses, or when t would pass T_MAX.
//   All arithmetic is signed Q16.16. Vectors pack as x[95:64], y[63:32], z[31:0].
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start                  start pulse (IDLE only)
//   ray_origin, ray_dir    ray definition, latched on start
//   busy                   high outside IDLE
//   sdf_req_valid/ready    SDF query handshake, sdf_pos = query position
//   sdf_resp_valid         SDF distance valid, sdf_dist = distance
//   done                   one-cycle completion pulse
//   hit, hit_t, hit_pos    result, held until the next accepted start
//   step_count             SDF responses consumed for this ray

// One vector lane of the position update: pos = org + (dir * t) in Q16.16.
module ray_march_lane (
  input  logic [31:0] org,
  input  logic [31:0] dir,
  input  logic [31:0] t,
  output logic [31:0] pos
);
  logic signed [63:0] dir_x, t_x, prod;
  logic               unused_prod;

  assign dir_x = {{32{dir[31]}}, dir};
  assign t_x   = {{32{t[31]}}, t};
  assign prod  = dir_x * t_x;
  // >>>16 then truncate to 32 bits is exactly prod[47:16]
  assign pos   = org + prod[47:16];
  assign unused_prod = ^{prod[63:48], prod[15:0]};
endmodule

module ray_march_ctrl #(
  parameter int                 MAX_STEPS = 64,
  parameter logic signed [31:0] EPS       = 32'sh0000_0041,
  parameter logic signed [31:0] T_MAX     = 32'sh0064_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [95:0] ray_origin,
  input  logic [95:0] ray_dir,
  output logic        busy,
  output logic        sdf_req_valid,
  input  logic        sdf_req_ready,
  output logic [95:0] sdf_pos,
  input  logic        sdf_resp_valid,
  input  logic [31:0] sdf_dist,
  output logic        done,
  output logic        hit,
  output logic [31:0] hit_t,
  output logic [95:0] hit_pos,
  output logic [7:0]  step_count
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 32;
  localparam logic [7:0] MAX_STEPS_B = 8'(MAX_STEPS);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_UPDATE, S_DONE} state_t;

  state_t                              state;
  logic [NUM_LANES-1:0][VEC_W-1:0]     org, dir, pos, pos_upd;
  logic signed [31:0]                  t, t_sum;
  logic [7:0]                          steps, steps_inc;

  assign steps_inc  = steps + 8'd1;
  assign t_sum      = t + $signed(sdf_dist);   // wraps mod 2^32
  assign sdf_pos    = pos;
  assign step_count = steps;

  ray_march_lane u_lane [NUM_LANES-1:0] (
    .org (org),
    .dir (dir),
    .t   (t),
    .pos (pos_upd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      org           <= '0;
      dir           <= '0;
      pos           <= '0;
      t             <= '0;
      steps         <= '0;
      busy          <= 1'b0;
      sdf_req_valid <= 1'b0;
      done          <= 1'b0;
      hit           <= 1'b0;
      hit_t         <= '0;
      hit_pos       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            org           <= ray_origin;
            dir           <= ray_dir;
            pos           <= ray_origin;
            t             <= '0;
            steps         <= '0;
            hit           <= 1'b0;
            hit_t         <= '0;
            hit_pos       <= '0;
            busy          <= 1'b1;
            sdf_req_valid <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (sdf_req_ready) begin
            sdf_req_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sdf_resp_valid) begin
            steps <= steps_inc;
            if ($signed(sdf_dist) < EPS || steps_inc == MAX_STEPS_B || t_sum > T_MAX) begin
              // t and pos are left as they were before this response
              hit     <= ($signed(sdf_dist) < EPS);
              hit_t   <= t;
              hit_pos <= pos;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              t     <= t_sum;
              state <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          pos           <= pos_upd;
          sdf_req_valid <= 1'b1;
          state         <= S_REQ;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy          <= 1'b0;
          sdf_req_valid <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end
endmodule
